axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 194 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI3-style slave bridging one transaction at a time onto a synchronous single-port SRAM.
//
// Ports
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   AW*_S / AWREADY_S      write address channel (ID, ADDR, LEN, SIZE, BURST)
//   W*_S  / WREADY_S       write data channel (DATA, STRB, LAST)
//   B*_S  / BREADY_S       write response channel (ID, RESP)
//   AR*_S / ARREADY_S      read address channel (ID, ADDR, LEN, SIZE, BURST)
//   R*_S  / RREADY_S       read data channel (ID, DATA, RESP, LAST)
//   CS, OE, WEB, A, DI, DO SRAM port; DO is valid the cycle after A is sampled with CS=1
//
// Every burst is handled as INCR of 32-bit beats; SIZE, BURST and AWLEN are ignored.
// Write bursts end on WLAST. The word address wraps modulo 2^MEM_AW.
module axi_sram_slave #(
  parameter int unsigned MEM_AW = 14
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // Write address channel
  input  logic [7:0]        AWID_S,
  input  logic [31:0]       AWADDR_S,
  input  logic [3:0]        AWLEN_S,
  input  logic [2:0]        AWSIZE_S,
  input  logic [1:0]        AWBURST_S,
  input  logic              AWVALID_S,
  output logic              AWREADY_S,
  // Write data channel
  input  logic [31:0]       WDATA_S,
  input  logic [3:0]        WSTRB_S,
  input  logic              WLAST_S,
  input  logic              WVALID_S,
  output logic              WREADY_S,
  // Write response channel
  output logic [7:0]        BID_S,
  output logic [1:0]        BRESP_S,
  output logic              BVALID_S,
  input  logic              BREADY_S,
  // Read address channel
  input  logic [7:0]        ARID_S,
  input  logic [31:0]       ARADDR_S,
  input  logic [3:0]        ARLEN_S,
  input  logic [2:0]        ARSIZE_S,
  input  logic [1:0]        ARBURST_S,
  input  logic              ARVALID_S,
  output logic              ARREADY_S,
  // Read data channel
  output logic [7:0]        RID_S,
  output logic [31:0]       RDATA_S,
  output logic [1:0]        RRESP_S,
  output logic              RLAST_S,
  output logic              RVALID_S,
  input  logic              RREADY_S,
  // SRAM port
  output logic              CS,
  output logic              OE,
  output logic [3:0]        WEB,
  output logic [MEM_AW-1:0] A,
  output logic [31:0]       DI,
  input  logic [31:0]       DO
);

  typedef enum logic [2:0] {StIdle, StRFetch, StRData, StWData, StWResp} state_e;

  localparam logic [MEM_AW-1:0] AddrOne = {{(MEM_AW-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;  // current beat word address
  logic [7:0]        id_q, id_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        cnt_q, cnt_d;
  // Last values driven onto A/DI, so the SRAM bus holds while idle.
  logic [MEM_AW-1:0] a_q;
  logic [31:0]       di_q;

  logic unused_inputs;
  assign unused_inputs = ^{AWLEN_S, AWSIZE_S, AWBURST_S, ARSIZE_S, ARBURST_S,
                           AWADDR_S[31:MEM_AW+2], AWADDR_S[1:0],
                           ARADDR_S[31:MEM_AW+2], ARADDR_S[1:0]};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      a_q     <= A;
      di_q    <= DI;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    id_d      = id_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    AWREADY_S = 1'b0;
    WREADY_S  = 1'b0;
    BID_S     = '0;
    BRESP_S   = 2'b00;
    BVALID_S  = 1'b0;
    ARREADY_S = 1'b0;
    RID_S     = '0;
    RDATA_S   = '0;
    RRESP_S   = 2'b00;
    RLAST_S   = 1'b0;
    RVALID_S  = 1'b0;
    CS        = 1'b0;
    OE        = 1'b0;
    WEB       = 4'hF;
    A         = a_q;
    DI        = di_q;

    unique case (state_q)
      StIdle: begin
        // Ready outputs are gated by reset so they read 0 while it is asserted.
        ARREADY_S = ARESETn;
        AWREADY_S = ARESETn & ~ARVALID_S;  // reads take priority over writes
        if (ARVALID_S) begin
          id_d    = ARID_S;
          addr_d  = ARADDR_S[MEM_AW+1:2];
          len_d   = ARLEN_S;
          cnt_d   = '0;
          state_d = StRFetch;
        end else if (AWVALID_S) begin
          id_d    = AWID_S;
          addr_d  = AWADDR_S[MEM_AW+1:2];
          state_d = StWData;
        end
      end

      StRFetch: begin
        CS      = 1'b1;
        OE      = 1'b1;
        A       = addr_q;
        state_d = StRData;
      end

      StRData: begin
        // Keep re-reading the same word so DO, and thus RDATA, stays stable under backpressure.
        CS       = 1'b1;
        OE       = 1'b1;
        A        = addr_q;
        RVALID_S = 1'b1;
        RDATA_S  = DO;
        RID_S    = id_q;
        RLAST_S  = (cnt_q == len_q);
        if (RREADY_S) begin
          if (cnt_q == len_q) begin
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + AddrOne;
            cnt_d   = cnt_q + 4'd1;
            state_d = StRFetch;
          end
        end
      end

      StWData: begin
        WREADY_S = 1'b1;
        if (WVALID_S) begin
          CS     = 1'b1;
          A      = addr_q;
          DI     = WDATA_S;
          WEB    = ~WSTRB_S;
          addr_d = addr_q + AddrOne;
          if (WLAST_S) begin
            state_d = StWResp;
          end
        end
      end

      StWResp: begin
        BVALID_S = 1'b1;
        BID_S    = id_q;
        if (BREADY_S) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: a driver issues randomized and directed AXI transactions
// and pushes expected responses computed from a word-level memory model; a negedge monitor pops
// and compares whenever the DUT presents a beat, response or SRAM write.
module tb_axi_sram_slave;

  localparam int unsigned AW = 14;
  localparam int unsigned MASK = (1 << AW) - 1;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b1;
  logic [7:0]    AWID_S = '0;
  logic [31:0]   AWADDR_S = '0;
  logic [3:0]    AWLEN_S = '0;
  logic [2:0]    AWSIZE_S = '0;
  logic [1:0]    AWBURST_S = '0;
  logic          AWVALID_S = 1'b0;
  logic          AWREADY_S;
  logic [31:0]   WDATA_S = '0;
  logic [3:0]    WSTRB_S = '0;
  logic          WLAST_S = 1'b0;
  logic          WVALID_S = 1'b0;
  logic          WREADY_S;
  logic [7:0]    BID_S;
  logic [1:0]    BRESP_S;
  logic          BVALID_S;
  logic          BREADY_S = 1'b0;
  logic [7:0]    ARID_S = '0;
  logic [31:0]   ARADDR_S = '0;
  logic [3:0]    ARLEN_S = '0;
  logic [2:0]    ARSIZE_S = '0;
  logic [1:0]    ARBURST_S = '0;
  logic          ARVALID_S = 1'b0;
  logic          ARREADY_S;
  logic [7:0]    RID_S;
  logic [31:0]   RDATA_S;
  logic [1:0]    RRESP_S;
  logic          RLAST_S;
  logic          RVALID_S;
  logic          RREADY_S = 1'b0;
  logic          CS;
  logic          OE;
  logic [3:0]    WEB;
  logic [AW-1:0] A;
  logic [31:0]   DI;
  logic [31:0]   do_q;

  always #5 ACLK = ~ACLK;

  axi_sram_slave #(.MEM_AW(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S),
    .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(do_q)
  );

  // Synchronous SRAM: byte writes, registered read data.
  logic [31:0] sram [0:(1<<AW)-1];
  always @(posedge ACLK) begin
    if (CS) begin
      for (int b = 0; b < 4; b++) begin
        if (!WEB[b]) sram[A][8*b +: 8] <= DI[8*b +: 8];
      end
      do_q <= sram[A];
    end
  end

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Reference model and scoreboard queues
  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] web; } wexp_t;
  typedef struct { logic [31:0] d; logic [7:0] id; logic last; } rexp_t;
  logic [31:0] ref_mem [int unsigned];
  wexp_t       wq [$];
  rexp_t       rq [$];
  logic [7:0]  bq [$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int aw_hs_cyc = 0;
  int last_r_cyc = 0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic ref_wr(input int unsigned w, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    cur = ref_rd(w);
    for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    ref_mem[w] = cur;
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return AWREADY_S;
      1:       return WREADY_S;
      2:       return ARREADY_S;
      3:       return RVALID_S;
      4:       return BVALID_S;
      default: return 1'b0;
    endcase
  endfunction

  // Returns at a negedge where the selected signal is high (handshake on the next posedge).
  task automatic wait_hi(input int s, input string nm);
    int n = 0;
    @(negedge ACLK);
    while (!sig(s)) begin
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL timeout_%s: got no handshake in 300 cycles, expected one", nm);
        return;
      end
      @(negedge ACLK);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int n,
                          input int bstall, input bit thr);
    int unsigned w;
    w = (addr >> 2) & MASK;
    step();
    AWID_S = id; AWADDR_S = addr; AWLEN_S = 4'($urandom);
    AWSIZE_S = 3'($urandom); AWBURST_S = 2'($urandom); AWVALID_S = 1'b1;
    wait_hi(0, "aw");
    step();
    AWVALID_S = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (thr) repeat ($urandom_range(0, 2)) step();
      WDATA_S = wd[i]; WSTRB_S = ws[i]; WLAST_S = (i == n - 1); WVALID_S = 1'b1;
      wq.push_back('{a: w, d: wd[i], web: ~ws[i]});
      if (i == n - 1) bq.push_back(id);
      wait_hi(1, "w");
      ref_wr(w, wd[i], ws[i]);
      step();
      WVALID_S = 1'b0; WLAST_S = 1'b0;
      w = (w + 1) & MASK;
    end
    repeat (bstall) step();
    BREADY_S = 1'b1;
    wait_hi(4, "b");
    step();
    BREADY_S = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                         input int stall_beat, input int stall_n, input bit thr);
    int unsigned w;
    int k;
    w = (addr >> 2) & MASK;
    for (int i = 0; i <= len; i++)
      rq.push_back('{d: ref_rd((w + i) & MASK), id: id, last: (i == len)});
    step();
    ARID_S = id; ARADDR_S = addr; ARLEN_S = 4'(len);
    ARSIZE_S = 3'($urandom); ARBURST_S = 2'($urandom); ARVALID_S = 1'b1;
    wait_hi(2, "ar");
    step();
    ARVALID_S = 1'b0;
    for (int i = 0; i <= len; i++) begin
      k = (i == stall_beat) ? stall_n : (thr ? int'($urandom_range(0, 3)) : 0);
      RREADY_S = 1'b0;
      repeat (k) step();
      RREADY_S = 1'b1;
      wait_hi(3, "r");
      step();
      RREADY_S = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_arready"}, ARREADY_S, 0);
    chk({tag, "_awready"}, AWREADY_S, 0);
    chk({tag, "_wready"}, WREADY_S, 0);
    chk({tag, "_bvalid"}, BVALID_S, 0);
    chk({tag, "_rvalid"}, RVALID_S, 0);
    chk({tag, "_rdata"}, RDATA_S, 0);
    chk({tag, "_rid"}, RID_S, 0);
    chk({tag, "_bid"}, BID_S, 0);
    chk({tag, "_resp"}, {RRESP_S, BRESP_S, RLAST_S}, 0);
    chk({tag, "_cs_oe"}, {CS, OE}, 0);
    chk({tag, "_web"}, WEB, 4'hF);
    chk({tag, "_a"}, A, 0);
    chk({tag, "_di"}, DI, 0);
  endtask

  // Monitor
  bit          rv_pend = 1'b0;
  int          exp_rv = 0;
  bit          r_stall = 1'b0;
  bit          b_stall = 1'b0;
  logic [31:0] r_hold;
  logic [7:0]  b_hold;
  initial begin
    wexp_t we;
    rexp_t re;
    logic [7:0] be;
    forever begin
      @(negedge ACLK);
      if (mon_en && ARESETn) begin
        if (WVALID_S && WREADY_S) begin
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_unexpected: got write beat A=%h, expected none", A);
          end else begin
            we = wq.pop_front();
            chk("w_addr", A, we.a);
            chk("w_data", DI, we.d);
            chk("w_web", WEB, we.web);
            chk("w_cs_oe", {CS, OE}, 2'b10);
          end
        end else begin
          chk("web_idle", WEB, 4'hF);
        end
        if (ARVALID_S && ARREADY_S) begin
          rv_pend = 1'b1;
          exp_rv = cyc + 2;
        end
        if (AWVALID_S && AWREADY_S) aw_hs_cyc = cyc;
        if (rq.size() == 0) chk("no_rvalid", RVALID_S, 0);
        if (bq.size() == 0) chk("no_bvalid", BVALID_S, 0);
        if (RVALID_S && rv_pend) begin
          chk("r_latency", cyc, exp_rv);
          rv_pend = 1'b0;
        end
        if (r_stall) begin
          chk("r_hold_valid", RVALID_S, 1);
          chk("r_hold_data", RDATA_S, r_hold);
        end
        if (b_stall) begin
          chk("b_hold_valid", BVALID_S, 1);
          chk("b_hold_id", BID_S, b_hold);
        end
        r_stall = RVALID_S && !RREADY_S;
        r_hold  = RDATA_S;
        b_stall = BVALID_S && !BREADY_S;
        b_hold  = BID_S;
        if (RVALID_S && RREADY_S && rq.size() > 0) begin
          re = rq.pop_front();
          chk("r_data", RDATA_S, re.d);
          chk("r_id", RID_S, re.id);
          chk("r_last", RLAST_S, re.last);
          chk("r_resp", RRESP_S, 0);
          if (re.last) begin
            last_r_cyc = cyc;
          end else begin
            rv_pend = 1'b1;
            exp_rv = cyc + 2;
          end
        end
        if (BVALID_S && BREADY_S && bq.size() > 0) begin
          be = bq.pop_front();
          chk("b_id", BID_S, be);
          chk("b_resp", BRESP_S, 0);
        end
      end else begin
        rv_pend = 1'b0;
        r_stall = 1'b0;
        b_stall = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  // Stimulus
  initial begin
    logic [7:0] id;
    int n;
    int len;
    #1 ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #2 chk_reset_vals("rst");
    @(posedge ACLK);
    #2 ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rel_arready", ARREADY_S, 1);
    chk("rel_awready", AWREADY_S, 1);
    mon_en = 1'b1;

    // Single read after single write
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(8'h21, 32'h40, 1, 0, 0);
    do_read(8'h15, 32'h40, 0, -1, 0, 0);

    // Burst write then read with a long mid-burst stall
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(8'hA5, 32'h100, 4, 0, 0);
    do_read(8'h3C, 32'h100, 3, 1, 7, 0);

    // Byte strobes, with B backpressure
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    do_write(8'h01, 32'h1000, 1, 0, 0);
    wd[0] = 32'h0; ws[0] = 4'b0101;
    do_write(8'h02, 32'h1000, 1, 5, 0);
    do_read(8'h03, 32'h1000, 0, -1, 0, 0);

    // Prefill random region words 0x200..0x21F and 0x300..0x301
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(8'($urandom), 32'h800 + 32'(r * 64), 16, 0, 0);
    end
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(8'h30, 32'hC00, 2, 0, 0);

    // Simultaneous AR and AW: read first, write in the first idle cycle after RLAST
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    fork
      do_read(8'h44, 32'h800, 2, -1, 0, 0);
      do_write(8'h55, 32'h1100, 2, 0, 0);
      begin
        @(posedge ACLK);
        @(negedge ACLK);
        chk("both_awready", AWREADY_S, 0);
        chk("both_arready", ARREADY_S, 1);
      end
    join
    chk("aw_after_rlast", aw_hs_cyc, last_r_cyc + 1);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      id = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 16);
        for (int i = 0; i < n; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        do_write(id, ($urandom & 32'hFFFF0000) | ((32'h200 + $urandom_range(0, 15)) << 2),
                 n, $urandom_range(0, 3), 1);
      end else begin
        len = $urandom_range(0, 15);
        do_read(id, ($urandom & 32'hFFFF0000) | ((32'h200 + $urandom_range(0, 15)) << 2),
                len, $urandom_range(0, len), $urandom_range(0, 4), 1);
      end
    end

    // Address wrap at the top of the SRAM
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(8'h66, ($urandom & 32'hFFFF0000) | 32'h0000FFFC, 2, 0, 0);
    do_read(8'h67, 32'h0000FFFC, 1, -1, 0, 0);

    // Reset during W_DATA: abort, no response, no further SRAM write
    step();
    AWID_S = 8'h77; AWADDR_S = 32'hC00; AWVALID_S = 1'b1;
    wait_hi(0, "aw_abort");
    step();
    AWVALID_S = 1'b0;
    wd[0] = $urandom;
    WDATA_S = wd[0]; WSTRB_S = 4'hF; WLAST_S = 1'b0; WVALID_S = 1'b1;
    wq.push_back('{a: 32'h300, d: wd[0], web: 4'h0});
    wait_hi(1, "w_abort");
    ref_wr(32'h300, wd[0], 4'hF);
    step();
    WDATA_S = 32'hBAD0BAD0;
    ARESETn = 1'b0;
    #1 chk_reset_vals("mid");
    wq.delete();
    repeat (3) @(posedge ACLK);
    #2 ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rel2_arready", ARREADY_S, 1);
    chk("rel2_awready", AWREADY_S, 1);
    step();
    WVALID_S = 1'b0;
    repeat (5) step();
    do_read(8'h78, 32'hC00, 1, -1, 0, 0);

    repeat (5) step();
    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    chk("wq_drained", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
